// File: rtl/fm_bram_0_reader_pkg.sv
// Shared definitions for the fm_bram_0 read-back path.
// Holds the reader FSM encoding and the fm_bram_0 layout constants that
// pool stage 2 (writer) and this reader must agree on.
package fm_bram_0_reader_pkg;

    // fm_bram_0 geometry shared with pool stage 2
    localparam int FM0_ADDR_W    = 6;
    localparam int FM0_DATA_W    = 1024;
    localparam int FM0_NUM_WORDS = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } fm_rd_state_t;

    // Number of stream beats one BRAM word is split into
    function automatic int fm0_beats(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

endpackage

// File: rtl/fm_bram_0_reader_if.sv
// Bundle of the reader's control, fm_bram_0 port B and output stream signals.
// master = the reader, slave = whoever drives start/BRAM data/ready.
interface fm_bram_0_reader_if
    import fm_bram_0_reader_pkg::*;
#(
    parameter int ADDR_W = FM0_ADDR_W,
    parameter int DATA_W = FM0_DATA_W,
    parameter int OUT_W  = 256
);
    logic              fm_read_en;
    logic              fm_bram_0_enb;
    logic [ADDR_W-1:0] fm_bram_0_addrb;
    logic [DATA_W-1:0] fm_bram_0_doutb;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              fm_read_finish;

    modport master (
        input  fm_read_en, fm_bram_0_doutb, out_ready,
        output fm_bram_0_enb, fm_bram_0_addrb, out_valid, out_data,
               out_last, busy, fm_read_finish
    );

    modport slave (
        output fm_read_en, fm_bram_0_doutb, out_ready,
        input  fm_bram_0_enb, fm_bram_0_addrb, out_valid, out_data,
               out_last, busy, fm_read_finish
    );
endinterface

// File: rtl/fm_bram_0_reader_serializer.sv
// Purpose: holds one BRAM word and emits it as OUT_W beats, LSB slice first.
// Latency: first beat valid the cycle after i_load; one beat per accepted handshake.
// Backpressure: data/last held while o_valid & !i_ready; i_load may coincide with final handshake.
module fm_word_serializer
    import fm_bram_0_reader_pkg::*;
#(
    parameter int DATA_W = FM0_DATA_W,
    parameter int OUT_W  = 256
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_last_word,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_last,
    output logic              o_final_hs
);
    localparam int BEATS = fm0_beats(DATA_W, OUT_W);
    localparam int B_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [B_W-1:0] B_LAST = B_W'(BEATS - 1);

    logic [DATA_W-1:0] r_word;
    logic [B_W-1:0]    r_b;
    logic              r_valid;
    logic [OUT_W-1:0]  r_data;
    logic              r_last;
    logic              r_last_word;

    logic              w_hs;
    logic [B_W-1:0]    w_b_inc;

    assign w_hs       = r_valid & i_ready;
    assign w_b_inc    = r_b + 1'b1;
    assign o_final_hs = w_hs & (r_b == B_LAST);
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_last     = r_last;

    // Word capture, beat advance and registered slice/last generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word      <= '0;
            r_b         <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_last_word <= 1'b0;
        end else if (i_load) begin
            r_word      <= i_word;
            r_b         <= '0;
            r_valid     <= 1'b1;
            r_data      <= i_word[OUT_W-1:0];
            r_last_word <= i_last_word;
            r_last      <= i_last_word && (BEATS == 1);
        end else if (w_hs) begin
            if (r_b == B_LAST) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_data  <= '0;
            end else begin
                r_b    <= w_b_inc;
                r_data <= r_word[int'(w_b_inc)*OUT_W +: OUT_W];
                r_last <= r_last_word && (w_b_inc == B_LAST);
            end
        end
    end

endmodule

// File: rtl/fm_bram_0_reader.sv
// Purpose: reads NUM_WORDS words from fm_bram_0 port B and streams them as OUT_W beats; FM_BRAM_0_READ_PREFETCH_EN overlaps the next read with SEND.
// Latency: 1+RD_LAT+BEATS cycles per word sequentially; gapless with prefetch when BEATS>RD_LAT.
// Backpressure: out_ready stalls the serializer; reads are never issued ahead of a free holding slot.
module fm_bram_0_reader
    import fm_bram_0_reader_pkg::*;
#(
    parameter int ADDR_W    = FM0_ADDR_W,
    parameter int DATA_W    = FM0_DATA_W,
    parameter int OUT_W     = 256,
    parameter int NUM_WORDS = FM0_NUM_WORDS,
    parameter int RD_LAT    = 1
)(
    input logic                clk,
    input logic                rst,
    fm_bram_0_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_W   = ADDR_W'(NUM_WORDS - 1);
    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

    fm_rd_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_w, w_w_nxt;
    logic [1:0]        r_lat, w_lat_nxt;
    logic              r_enb;
    logic [ADDR_W-1:0] r_addrb;
    logic              r_busy;
    logic              r_fin;

    logic              w_load;
    logic [DATA_W-1:0] w_load_word;
    logic              w_load_last;
    logic              w_issue;
    logic              w_ser_valid;
    logic              w_ser_final;
    logic [OUT_W-1:0]  w_ser_data;
    logic              w_ser_last;

`ifdef FM_BRAM_0_READ_PREFETCH_EN
    localparam logic [1:0] LAT_PF = 2'(RD_LAT);

    logic [DATA_W-1:0] r_hold;
    logic              r_hold_vld;
    logic              r_pf_wait;
    logic [1:0]        r_pf_lat;
    logic              r_pend;
    logic              w_cap;
    logic              w_next_avail;
    logic              w_take;
    logic [DATA_W-1:0] w_next_word;

    // Prefetched data lands RD_LAT cycles after its enb cycle; a same-cycle
    // arrival is forwarded straight from doutb.
    assign w_cap        = r_pf_wait && (r_pf_lat == LAT_PF);
    assign w_next_avail = r_hold_vld || w_cap;
    assign w_next_word  = r_hold_vld ? r_hold : bus.fm_bram_0_doutb;
    assign w_take       = w_load && (r_state == ST_SEND);
    // Every non-final word entering SEND launches the read of its successor
    assign w_issue      = w_load && (w_w_nxt != LAST_W);
`else
    assign w_issue      = 1'b0;
`endif

    assign w_load_last = (w_w_nxt == LAST_W);

    // Next-state, word counter, wait counter and serializer load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_lat_nxt   = r_lat;
        w_load      = 1'b0;
        w_load_word = bus.fm_bram_0_doutb;
        case (r_state)
            ST_IDLE: begin
                w_w_nxt = '0;
                if (bus.fm_read_en) w_state_nxt = ST_RD;
            end
            ST_RD: begin
                w_lat_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_lat_nxt = r_lat + 2'd1;
                end
            end
            ST_SEND: begin
`ifdef FM_BRAM_0_READ_PREFETCH_EN
                w_load_word = w_next_word;
                if (w_ser_final) begin
                    if (r_w == LAST_W) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_w_nxt = r_w + 1'b1;
                        w_load  = w_next_avail;
                    end
                end else if (r_pend && w_next_avail) begin
                    w_load = 1'b1;
                end
`else
                if (w_ser_final) begin
                    if (r_w == LAST_W) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_w_nxt     = r_w + 1'b1;
                        w_state_nxt = ST_RD;
                    end
                end
`endif
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_w     <= '0;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    // Registered BRAM port B controls and run status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enb   <= 1'b0;
            r_addrb <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_enb  <= (w_state_nxt == ST_RD) || w_issue;
            r_busy <= (w_state_nxt != ST_IDLE);
            r_fin  <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_RD)
                r_addrb <= w_w_nxt;
            else if (w_issue)
                r_addrb <= w_w_nxt + 1'b1;
        end
    end

`ifdef FM_BRAM_0_READ_PREFETCH_EN
    // Single outstanding prefetch: latency tracking, holding register, deferred load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_pf_wait  <= 1'b0;
            r_pf_lat   <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pf_wait <= 1'b1;
                r_pf_lat  <= '0;
            end else if (w_cap) begin
                r_pf_wait <= 1'b0;
            end else if (r_pf_wait) begin
                r_pf_lat <= r_pf_lat + 2'd1;
            end

            if (w_cap && !w_take) begin
                r_hold     <= bus.fm_bram_0_doutb;
                r_hold_vld <= 1'b1;
            end else if (w_take) begin
                r_hold_vld <= 1'b0;
            end

            if (w_take)
                r_pend <= 1'b0;
            else if ((r_state == ST_SEND) && w_ser_final && (r_w != LAST_W))
                r_pend <= 1'b1;
        end
    end
`endif

    fm_word_serializer #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_word      (w_load_word),
        .i_last_word (w_load_last),
        .i_ready     (bus.out_ready),
        .o_valid     (w_ser_valid),
        .o_data      (w_ser_data),
        .o_last      (w_ser_last),
        .o_final_hs  (w_ser_final)
    );

    assign bus.fm_bram_0_enb   = r_enb;
    assign bus.fm_bram_0_addrb = r_addrb;
    assign bus.busy            = r_busy;
    assign bus.fm_read_finish  = r_fin;
    assign bus.out_valid       = w_ser_valid;
    assign bus.out_data        = w_ser_data;
    assign bus.out_last        = w_ser_last;

endmodule

// File: tb/tb_fm_bram_0_reader.sv
// Bench for fm_bram_0_reader: default instance (7 words, RD_LAT=1) and a
// single-word instance (RD_LAT=2), each with its own BRAM model and scoreboard.
module tb_fm_bram_0_reader;
    localparam int AW = 6, DW = 1024, OW = 256, NW = 7, BEATS = DW / OW;
`ifdef FM_BRAM_0_READ_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif
    localparam int LAT_BASE  = (PF != 0) ? 30 : 42;
    localparam int SPAN_BASE = (PF != 0) ? 27 : 39;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fm_bram_0_reader_if #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) ifa ();
    fm_bram_0_reader_if #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) ifb ();

    fm_bram_0_reader #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW), .NUM_WORDS(NW), .RD_LAT(1))
        u_dut (.clk(clk), .rst(rst), .bus(ifa));
    fm_bram_0_reader #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW), .NUM_WORDS(1), .RD_LAT(2))
        u_dut1 (.clk(clk), .rst(rst), .bus(ifb));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // word k holds 16-bit elements k*64+i
    function automatic logic [DW-1:0] mk_word(input int k);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 16; i++) w[i*16 +: 16] = 16'(k * 64 + i);
        return w;
    endfunction

    // BRAM models: latency 1 for instance A, latency 2 for instance B
    logic [DW-1:0] b_s1;
    always @(posedge clk) begin
        if (ifa.fm_bram_0_enb) ifa.fm_bram_0_doutb <= mk_word(int'(ifa.fm_bram_0_addrb));
    end
    always @(posedge clk) begin
        if (ifb.fm_bram_0_enb) b_s1 <= mk_word(int'(ifb.fm_bram_0_addrb));
        ifb.fm_bram_0_doutb <= b_s1;
    end

    // Scoreboard state, instance A
    logic [OW-1:0] q_dat[$];
    bit            q_last[$];
    int            q_addr[$];
    int  nbeats, nfin, nenb, rd_cyc, fin_cyc, hs_first, hs_last;
    bit  first_enb;
    bit  prev_vld, prev_rdy;

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (ifa.fm_bram_0_enb) begin
                nenb++;
                if (first_enb) begin
                    rd_cyc    = cyc;
                    first_enb = 1'b0;
                end else begin
                    chk("enb_during_send", ifa.out_valid, PF);
                end
                chk("addr_expected", q_addr.size() > 0, 1);
                if (q_addr.size() > 0) chk("addrb", ifa.fm_bram_0_addrb, q_addr.pop_front());
            end
            if (prev_vld && !prev_rdy) chk("stall_valid_held", ifa.out_valid, 1);
            if (ifa.out_valid && !ifa.out_ready && q_dat.size() > 0) begin
                chk("stall_data", ifa.out_data, q_dat[0]);
                chk("stall_last", ifa.out_last, q_last[0]);
            end
            if (ifa.out_valid && ifa.out_ready) begin
                chk("beat_expected", q_dat.size() > 0, 1);
                if (q_dat.size() > 0) begin
                    chk("beat_data", ifa.out_data, q_dat.pop_front());
                    chk("beat_last", ifa.out_last, q_last.pop_front());
                end
                if (nbeats == 0) hs_first = cyc;
                hs_last = cyc;
                nbeats++;
            end
            if (ifa.fm_read_finish) begin
                nfin++;
                fin_cyc = cyc;
            end
            prev_vld = ifa.out_valid;
            prev_rdy = ifa.out_ready;
        end
    end

    // Scoreboard state, instance B
    logic [OW-1:0] qb_dat[$];
    bit            qb_last[$];
    int  b_beats, b_fin, b_enb, b_fin_cyc, b_hs_last;

    always @(negedge clk) begin
        if (!rst) begin
            if (ifb.fm_bram_0_enb) begin
                b_enb++;
                chk("b_addrb", ifb.fm_bram_0_addrb, 0);
            end
            if (ifb.out_valid && ifb.out_ready) begin
                chk("b_beat_expected", qb_dat.size() > 0, 1);
                if (qb_dat.size() > 0) begin
                    chk("b_beat_data", ifb.out_data, qb_dat.pop_front());
                    chk("b_beat_last", ifb.out_last, qb_last.pop_front());
                end
                b_beats++;
                b_hs_last = cyc;
            end
            if (ifb.fm_read_finish) begin
                b_fin++;
                b_fin_cyc = cyc;
            end
        end
    end

    task automatic start_a();
        logic [DW-1:0] w;
        for (int k = 0; k < NW; k++) begin
            q_addr.push_back(k);
            w = mk_word(k);
            for (int b = 0; b < BEATS; b++) begin
                q_dat.push_back(w[b*OW +: OW]);
                q_last.push_back((k == NW - 1) && (b == BEATS - 1));
            end
        end
        nbeats = 0; nfin = 0; nenb = 0; hs_first = 0; hs_last = 0;
        rd_cyc = 0; fin_cyc = 0; first_enb = 1'b1;
        ifa.fm_read_en = 1'b1;
        @(posedge clk); #1;
        ifa.fm_read_en = 1'b0;
    endtask

    // mode 0: ready=1; 1: random ready; 2: 5-cycle stall at beat 3; 3: ready=1 + start re-pulse at beat 5
    task automatic run_a(input int mode);
        bit pulsed = 1'b0;
        int stall  = 0;
        for (int i = 0; i < 600; i++) begin
            if (nfin > 0) break;
            case (mode)
                1: ifa.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (nbeats == 3 && !pulsed) begin
                        pulsed = 1'b1;
                        stall  = 5;
                    end
                    ifa.out_ready = (stall == 0);
                    if (stall > 0) stall--;
                end
                default: ifa.out_ready = 1'b1;
            endcase
            ifa.fm_read_en = (mode == 3) && (nbeats == 5) && !pulsed;
            if (mode == 3 && nbeats == 5) pulsed = 1'b1;
            @(posedge clk); #1;
        end
        ifa.fm_read_en = 1'b0;
        chk("finish_seen", nfin, 1);
        chk("beat_count", nbeats, NW * BEATS);
        chk("queue_drained", q_dat.size(), 0);
        chk("read_count", nenb, NW);
        chk("finish_after_last_beat", fin_cyc - hs_last, 1);
        if (mode == 1) chk("finish_latency_min", (fin_cyc - rd_cyc) >= LAT_BASE, 1);
        else chk("finish_latency", fin_cyc - rd_cyc, (mode == 2) ? LAT_BASE + 5 : LAT_BASE);
        if (mode == 0) chk("beat_span", hs_last - hs_first, SPAN_BASE);
    endtask

    initial begin
        logic [DW-1:0] w0;
        ifa.fm_read_en = 1'b0; ifa.out_ready = 1'b0;
        ifb.fm_read_en = 1'b0; ifb.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enb", ifa.fm_bram_0_enb, 0);
        chk("rst_addrb", ifa.fm_bram_0_addrb, 0);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_data", ifa.out_data, 0);
        chk("rst_last", ifa.out_last, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_finish", ifa.fm_read_finish, 0);
        chk("rst_b_busy", ifb.busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", ifa.busy, 0);

        // basic run, then backpressure, then fixed stall
        start_a();
        chk("busy_at_rd", ifa.busy, 1);
        run_a(0);
        start_a(); run_a(1);
        start_a(); run_a(2);

        // start re-pulse mid-run must not queue a second run
        start_a(); run_a(3);
        repeat (10) @(posedge clk);
        #1;
        chk("repulse_busy_after", ifa.busy, 0);
        chk("repulse_no_extra_read", nenb, NW);
        chk("repulse_single_finish", nfin, 1);

        // reset at beat 10
        start_a();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 200 && nbeats < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_beat10", nbeats, 10);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", ifa.out_valid, 0);
        chk("mid_rst_data", ifa.out_data, 0);
        chk("mid_rst_last", ifa.out_last, 0);
        chk("mid_rst_enb", ifa.fm_bram_0_enb, 0);
        chk("mid_rst_busy", ifa.busy, 0);
        chk("mid_rst_finish", ifa.fm_read_finish, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_finish", nfin, 0);
        q_dat.delete(); q_last.delete(); q_addr.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", ifa.busy, 0);
        start_a(); run_a(0);

        // single word, RD_LAT=2
        w0 = mk_word(0);
        for (int b = 0; b < BEATS; b++) begin
            qb_dat.push_back(w0[b*OW +: OW]);
            qb_last.push_back(b == BEATS - 1);
        end
        b_beats = 0; b_fin = 0; b_enb = 0; b_fin_cyc = 0; b_hs_last = 0;
        ifb.out_ready = 1'b1;
        ifb.fm_read_en = 1'b1;
        @(posedge clk); #1;
        ifb.fm_read_en = 1'b0;
        for (int i = 0; i < 100 && b_fin == 0; i++) begin
            @(posedge clk); #1;
        end
        chk("b_finish_seen", b_fin, 1);
        chk("b_beat_count", b_beats, BEATS);
        chk("b_read_count", b_enb, 1);
        chk("b_finish_after_last", b_fin_cyc - b_hs_last, 1);
        chk("b_queue_drained", qb_dat.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fm_bram_0_reader.md
Name: fm_bram_0_reader

Overview:
- Reads pooled feature-map words back out of fm_bram_0, which pool stage 2 fills through port A, and streams them to the next layer (FC input) over a valid/ready interface.
- Uses fm_bram_0 port B as read-only.
- Splits each 1024-bit BRAM word into OUT_W-bit beats, sent LSB first.
- Signals completion with a one-cycle finish pulse.

Parameters:
- ADDR_W, 6: fm_bram_0 address width.
- DATA_W, 1024: fm_bram_0 word width.
- OUT_W, 256: stream beat width. DATA_W must be an integer multiple; BEATS = DATA_W/OUT_W.
- NUM_WORDS, 7: words read per run, 1..2^ADDR_W.
- RD_LAT, 1: BRAM read latency in cycles, 1 or 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fm_read_en  in  1  start pulse; sampled only in IDLE.
- fm_bram_0_enb  out  1  port B read enable.
- fm_bram_0_addrb  out  ADDR_W  port B read address.
- fm_bram_0_doutb  in  DATA_W  port B read data.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  beat payload.
- out_last  out  1  high on the final beat of the run.
- busy  out  1  high from start until the finish pulse, inclusive.
- fm_read_finish  out  1  one-cycle done pulse.

Behaviour:
- Reset: all outputs are registered and clear to 0. State=IDLE; word counter, beat counter, word register and latency counter all clear to 0.
- FSM states: IDLE -> RD -> WAIT -> SEND -> (RD | DONE) -> IDLE.
- IDLE:
  - fm_read_en=1 -> RD next cycle.
  - busy rises in the same cycle as RD.
  - word counter w=0.
- RD (1 cycle):
  - fm_bram_0_enb=1, fm_bram_0_addrb=w.
  - Next state: WAIT.
- WAIT (RD_LAT cycles):
  - enb=0.
  - On the last WAIT cycle, fm_bram_0_doutb is captured into the word register.
  - Next state: SEND with beat counter b=0.
- SEND:
  - out_valid=1, out_data = word[b*OUT_W +: OUT_W].
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - Handshake = out_valid & out_ready. Each handshake increments b.
  - At b=BEATS-1:
    - If w<NUM_WORDS-1: w++, go to RD.
    - Otherwise: go to DONE.
  - out_last=1 only when w=NUM_WORDS-1 and b=BEATS-1.
- DONE (1 cycle):
  - fm_read_finish=1 and busy=1 in this cycle.
  - Then IDLE with busy=0.
- Throughput without the optional feature: a word costs 1+RD_LAT+BEATS cycles with out_ready held at 1. Defaults give 6 cycles/word and 42 cycles from RD to DONE.
- fm_read_en while busy is ignored and not queued.
- out_ready is ignored outside SEND.
- NUM_WORDS=1: one RD, BEATS beats, the last one flagged with out_last.
- Address never exceeds NUM_WORDS-1; no wrap-around within a run.
- Reset asserted mid-run: immediate return to IDLE. No finish pulse; out_valid drops asynchronously.
- fm_bram_0_doutb is never sampled outside the capture cycle.

Optional Feature:
- Macro: FM_BRAM_0_READ_PREFETCH_EN.
- With the macro defined:
  - A second DATA_W holding register is added.
  - During SEND of word w (w<NUM_WORDS-1), the read of w+1 is issued in the first SEND cycle and captured into the holding register after RD_LAT.
  - On the final-beat handshake of word w, the held word moves into the word register. SEND continues at b=0 with no RD/WAIT gap.
  - Stream is gapless, 1 beat/cycle, when out_ready=1 and BEATS>RD_LAT.
  - Must remain correct if out_ready stalls before the prefetch lands.
- Without the macro: the sequential behaviour above; no holding register.

Decomposition:
- Shared package contents:
  - FSM state encoding (IDLE, RD, WAIT, SEND, DONE).
  - Default constants for FM0_ADDR_W, FM0_DATA_W and FM0_NUM_WORDS, shared with pool stage 2 so both ends agree on the fm_bram_0 layout.
- One natural sub-module: fm_word_serializer. It holds the word register and beat counter, and does slicing, valid/ready holding and last-beat detection. The top keeps the FSM and BRAM addressing.

Test Plan:
- Basic run:
  - Stimulus: BRAM model with RD_LAT=1, word k filled with 16-bit elements equal to k*64+index; pulse fm_read_en; out_ready=1.
  - Required: 28 beats in order, addrb sequence 0..6, out_last only on beat 28, fm_read_finish exactly 42 cycles after RD entry.
- Backpressure:
  - Stimulus: out_ready toggled pseudo-randomly.
  - Required: identical beat sequence; out_data stable during every stall; no beat dropped or duplicated.
- Single word:
  - Stimulus: NUM_WORDS=1, RD_LAT=2.
  - Required: one enb pulse at addr 0; 4 beats; finish one cycle after the final handshake.
- Ignored start and mid-run reset:
  - Stimulus: fm_read_en re-pulsed at beat 5; rst asserted at beat 10.
  - Required: the re-pulse is ignored; on reset all outputs go to 0 immediately and no finish pulse is produced. A fresh run afterwards restarts from addr 0.
- Prefetch:
  - Stimulus: macro defined, out_ready=1.
  - Required: 28 beats on 28 consecutive cycles, and enb for the next word asserted during SEND.
- Prefetch under stall:
  - Stimulus: macro defined, out_ready=0 held for 5 cycles at beat 3.
  - Required: data is still correct and the stream is gapless once out_ready returns.
